spi_frame_responder: RTL and testbench

- SPI responder (slave) for frames clocked by our SCLK generator: CS active-low, SCLK idles low, mode 1 (CPOL=0, CPHA=1).
- Oversamples the external SCLK, CS and MOSI with the 50 MHz system clock.
- Deserialises MOSI into fixed-width words and serialises local words onto MISO, WORDS_PER_FRAME words per CS assertion.
- Serves as the ADC-side model/loopback target for the acquisition path and as a board-to-board responder.

---
 rtl/spi_resp_pkg.sv | 20 ++
 rtl/spi_frame_responder_if.sv | 33 +++
 rtl/spi_input_sync.sv | 33 +++
 rtl/spi_frame_responder.sv | 158 +++++++++++++++
 tb/tb_spi_frame_responder.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_resp_pkg.sv
// Shared constants and types for the SPI frame responder.
// Mode 1 responder: MOSI sampled on SCLK fall, MISO driven on SCLK rise.
package spi_resp_pkg;

   localparam int SYNC_STAGES    = 2;
   localparam int MIN_SCLK_PHASE = 4;
   localparam int IDX_W          = 4;
   localparam int WCNT_W         = IDX_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   function automatic int flush_cycles();
      return SYNC_STAGES + 1;
   endfunction

endpackage

// File: rtl/spi_frame_responder_if.sv
// Pin and word-level bundle of the SPI frame responder.
// master = the SPI host plus the local word source/sink, slave = responder.
interface spi_frame_responder_if
   import spi_resp_pkg::*;
#(
   parameter int WORD_BITS = 24
);

   logic                 spi_sclk;
   logic                 spi_cs_n;
   logic                 spi_mosi;
   logic                 spi_miso;
   logic [WORD_BITS-1:0] tx_data;
   logic                 tx_load;
   logic [WORD_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic [IDX_W-1:0]     rx_word_idx;
   logic                 frame_done;
   logic                 frame_abort;

   modport slave (
      input  spi_sclk, spi_cs_n, spi_mosi, tx_data,
      output spi_miso, tx_load, rx_data, rx_valid,
      output rx_word_idx, frame_done, frame_abort
   );

   modport master (
      output spi_sclk, spi_cs_n, spi_mosi, tx_data,
      input  spi_miso, tx_load, rx_data, rx_valid,
      input  rx_word_idx, frame_done, frame_abort
   );

endinterface

// File: rtl/spi_input_sync.sv
// Two-flop synchroniser plus history flop for one asynchronous pin.
// Edges appear in the cycle after the second sync stage settles.
module spi_input_sync
   import spi_resp_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   hist;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync <= {SYNC_STAGES{RST_VAL}};
         hist <= RST_VAL;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pin};
         hist <= sync[SYNC_STAGES-1];
      end
   end

   assign level = sync[SYNC_STAGES-1];
   assign rise  = level & ~hist;
   assign fall  = ~level & hist;

endmodule

// File: rtl/spi_frame_responder.sv
// SPI mode-1 responder: fixed-width words, WORDS_PER_FRAME per CS assertion.
// All SPI pins are oversampled by clk; outputs are registered.
module spi_frame_responder
   import spi_resp_pkg::*;
#(
   parameter int WORD_BITS       = 24,
   parameter int WORDS_PER_FRAME = 5
) (
   input logic                  clk,
   input logic                  rst_n,
   spi_frame_responder_if.slave bus
);

   localparam int BW = $clog2(WORD_BITS + 1);
   localparam logic [BW-1:0] WB = BW'(WORD_BITS);
   localparam logic [WCNT_W-1:0] LAST = WCNT_W'(WORDS_PER_FRAME - 1);
   localparam logic [1:0] FLUSH = 2'(flush_cycles());

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   spi_input_sync #(.RST_VAL(1'b0)) u_sclk (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (bus.spi_sclk),
      .level (sclk_lvl),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_input_sync #(.RST_VAL(1'b1)) u_cs (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (bus.spi_cs_n),
      .level (cs_lvl),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_input_sync #(.RST_VAL(1'b0)) u_mosi (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (bus.spi_mosi),
      .level (mosi_lvl),
      .rise  (mosi_rise),
      .fall  (mosi_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

   state_t               state;
   logic [BW-1:0]        bit_cnt;
   logic [WCNT_W-1:0]    word_cnt;
   logic [WORD_BITS-1:0] tx_shift;
   logic [WORD_BITS-1:0] rx_shift;
   logic [1:0]           flush_cnt;
   logic                 armed;

   logic                 miso;
   logic                 tx_load;
   logic [WORD_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic [IDX_W-1:0]     rx_word_idx;
   logic                 frame_done;
   logic                 frame_abort;

   // armed blocks a frame start until CS has been seen high after reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         word_cnt    <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         flush_cnt   <= '0;
         armed       <= 1'b0;
         miso        <= 1'b0;
         tx_load     <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_word_idx <= '0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         tx_load     <= 1'b0;
         rx_valid    <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;

         if (flush_cnt != FLUSH) begin
            flush_cnt <= flush_cnt + 2'd1;
         end else if (cs_lvl) begin
            armed <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (cs_fall && armed) begin
                  tx_shift <= bus.tx_data;
                  tx_load  <= 1'b1;
                  bit_cnt  <= '0;
                  word_cnt <= '0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  state       <= IDLE;
                  miso        <= 1'b0;
                  bit_cnt     <= '0;
                  frame_abort <= 1'b1;
               end else if (bit_cnt == WB) begin
                  rx_data     <= rx_shift;
                  rx_word_idx <= word_cnt[IDX_W-1:0];
                  rx_valid    <= 1'b1;
                  bit_cnt     <= '0;
                  word_cnt    <= word_cnt + 1'b1;
                  if (word_cnt < LAST) begin
                     tx_shift <= bus.tx_data;
                     tx_load  <= 1'b1;
                  end else begin
                     frame_done <= 1'b1;
                     state      <= DONE;
                  end
               end else if (sclk_rise) begin
                  miso     <= tx_shift[WORD_BITS-1];
                  tx_shift <= {tx_shift[WORD_BITS-2:0], 1'b0};
               end else if (sclk_fall) begin
                  rx_shift <= {rx_shift[WORD_BITS-2:0], mosi_lvl};
                  bit_cnt  <= bit_cnt + 1'b1;
               end
            end
            DONE: begin
               if (cs_rise) begin
                  state <= IDLE;
                  miso  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         if (state == IDLE && cs_rise) begin
            miso <= 1'b0;
         end
      end
   end

   assign bus.spi_miso    = miso;
   assign bus.tx_load     = tx_load;
   assign bus.rx_data     = rx_data;
   assign bus.rx_valid    = rx_valid;
   assign bus.rx_word_idx = rx_word_idx;
   assign bus.frame_done  = frame_done;
   assign bus.frame_abort = frame_abort;

endmodule

// File: tb/tb_spi_frame_responder.sv
// Directed bench for spi_frame_responder: 24x5 instance plus an 8x1
// instance for the latency check, sharing one SPI host selected by sel.
module tb_spi_frame_responder;
   import spi_resp_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic cs_n = 1'b1;
   logic mosi = 1'b0;
   logic sel = 1'b0;

   int pass_cnt = 0;
   int check_cnt = 0;

   int tx_cnt = 0;
   int abort_cnt = 0;
   int done_cnt = 0;
   logic [23:0] rxq_d[$];
   logic [3:0]  rxq_i[$];
   logic        rxq_f[$];
   logic        miso_q[$];

   logic [23:0] nom[5] = '{24'hA5A5A5, 24'h000001, 24'hFFFFFF,
                           24'h123456, 24'h800000};

   always #10 clk = ~clk;

   function automatic logic [23:0] tx_pat(input int n);
      case (n % 5)
         0: return 24'hC00000;
         1: return 24'h111111;
         2: return 24'h222222;
         3: return 24'h333333;
         default: return 24'h444444;
      endcase
   endfunction

   spi_frame_responder_if #(.WORD_BITS(24)) bus ();
   spi_frame_responder_if #(.WORD_BITS(8))  bus2 ();

   assign bus.spi_sclk  = sel ? 1'b0 : sclk;
   assign bus.spi_cs_n  = sel ? 1'b1 : cs_n;
   assign bus.spi_mosi  = mosi;
   assign bus.tx_data   = tx_pat(tx_cnt);
   assign bus2.spi_sclk = sel ? sclk : 1'b0;
   assign bus2.spi_cs_n = sel ? cs_n : 1'b1;
   assign bus2.spi_mosi = mosi;
   assign bus2.tx_data  = 8'hC3;

   spi_frame_responder #(.WORD_BITS(24), .WORDS_PER_FRAME(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   spi_frame_responder #(.WORD_BITS(8), .WORDS_PER_FRAME(1)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   always begin
      @(posedge clk);
      #1;
      if (bus.rx_valid) begin
         rxq_d.push_back(bus.rx_data);
         rxq_i.push_back(bus.rx_word_idx);
         rxq_f.push_back(bus.frame_done);
      end
      if (bus.tx_load) tx_cnt++;
      if (bus.frame_abort) abort_cnt++;
      if (bus.frame_done) done_cnt++;
   end

   task automatic sclk_bit(input logic b);
      sclk = 1'b1;
      mosi = b;
      repeat (7) @(negedge clk);
      miso_q.push_back(sel ? bus2.spi_miso : bus.spi_miso);
      sclk = 1'b0;
      repeat (7) @(negedge clk);
   endtask

   task automatic send_word(input logic [23:0] w, input int n);
      for (int i = 0; i < n; i++) sclk_bit(w[23-i]);
   endtask

   task automatic cs_fall();
      cs_n = 1'b0;
      repeat (7) @(negedge clk);
   endtask

   task automatic cs_rise();
      cs_n = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      check_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      if (bus.spi_miso !== 1'b0) $display("FAIL rst_miso: got %b expected 0", bus.spi_miso);
      else pass_cnt++;
      check_cnt++;
      if (bus.rx_data !== 24'h0) $display("FAIL rst_rx_data: got %h expected 0", bus.rx_data);
      else pass_cnt++;
      check_cnt++;
      if ({bus.rx_valid, bus.tx_load, bus.frame_done, bus.frame_abort} !== 4'b0)
         $display("FAIL rst_pulses: got %b expected 0000",
                  {bus.rx_valid, bus.tx_load, bus.frame_done, bus.frame_abort});
      else pass_cnt++;
      check_cnt++;
      if (bus.rx_word_idx !== 4'd0) $display("FAIL rst_idx: got %0d expected 0", bus.rx_word_idx);
      else pass_cnt++;
      check_cnt++;
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic frame_rx_check(input string tag, input int base,
                                 input logic [23:0] w[5]);
      for (int k = 0; k < 5; k++) begin
         check_cnt++;
         if (base + k >= rxq_d.size()) begin
            $display("FAIL %s_word%0d: got none expected %h", tag, k, w[k]);
         end else if (rxq_d[base+k] !== w[k] || rxq_i[base+k] !== 4'(k) ||
                      rxq_f[base+k] !== (k == 4)) begin
            $display("FAIL %s_word%0d: got %h idx %0d done %b expected %h idx %0d done %b",
                     tag, k, rxq_d[base+k], rxq_i[base+k], rxq_f[base+k],
                     w[k], k, (k == 4));
         end else begin
            pass_cnt++;
         end
      end
   endtask

   task automatic test_nominal_frame();
      int rb = rxq_d.size();
      int db = done_cnt;
      int ab = abort_cnt;
      cs_fall();
      for (int w = 0; w < 5; w++) send_word(nom[w], 24);
      cs_rise();
      chk("nom_rx_count", 32'(rxq_d.size() - rb), 32'd5);
      frame_rx_check("nom", rb, nom);
      chk("nom_done_count", 32'(done_cnt - db), 32'd1);
      chk("nom_abort_count", 32'(abort_cnt - ab), 32'd0);
   endtask

   task automatic test_tx_path();
      int tb0 = tx_cnt;
      int mb = miso_q.size();
      logic [23:0] got;
      cs_fall();
      for (int w = 0; w < 5; w++) send_word(nom[4-w], 24);
      chk("tx_load_count", 32'(tx_cnt - tb0), 32'd5);
      for (int k = 0; k < 5; k++) begin
         got = '0;
         for (int i = 0; i < 24; i++) got = {got[22:0], miso_q[mb + k*24 + i]};
         check_cnt++;
         if (got !== tx_pat(tb0 + k))
            $display("FAIL tx_word%0d: got %h expected %h", k, got, tx_pat(tb0 + k));
         else
            pass_cnt++;
      end
      cs_rise();
      chk("tx_miso_idle", 32'(bus.spi_miso), 32'd0);
   endtask

   task automatic test_abort();
      int rb = rxq_d.size();
      int ab = abort_cnt;
      int db = done_cnt;
      cs_fall();
      send_word(24'h111111, 24);
      send_word(24'h222222, 24);
      send_word(24'h333333, 10);
      cs_rise();
      chk("abort_count", 32'(abort_cnt - ab), 32'd1);
      chk("abort_rx_count", 32'(rxq_d.size() - rb), 32'd2);
      chk("abort_rx_data", 32'(bus.rx_data), 32'h222222);
      chk("abort_rx_idx", 32'(bus.rx_word_idx), 32'd1);
      chk("abort_miso", 32'(bus.spi_miso), 32'd0);
      chk("abort_no_done", 32'(done_cnt - db), 32'd0);
      rb = rxq_d.size();
      cs_fall();
      for (int w = 0; w < 5; w++) send_word(nom[w], 24);
      cs_rise();
      frame_rx_check("post_abort", rb, nom);
   endtask

   task automatic test_extra_clocks();
      int rb;
      int tb0;
      int ab = abort_cnt;
      cs_fall();
      for (int w = 0; w < 5; w++) send_word(nom[w], 24);
      rb = rxq_d.size();
      tb0 = tx_cnt;
      send_word(24'hFFFFFF, 24);
      send_word(24'h555555, 6);
      cs_rise();
      chk("extra_rx_count", 32'(rxq_d.size() - rb), 32'd0);
      chk("extra_tx_load", 32'(tx_cnt - tb0), 32'd0);
      chk("extra_abort", 32'(abort_cnt - ab), 32'd0);
      chk("extra_miso_idle", 32'(bus.spi_miso), 32'd0);
   endtask

   task automatic test_reset_mid_frame();
      int rb;
      int tb0;
      int ab;
      cs_fall();
      send_word(nom[0], 7);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_outputs",
          {bus.rx_data, bus.rx_word_idx, bus.spi_miso, bus.rx_valid,
           bus.tx_load, bus.frame_done},
          32'd0);
      chk("mrst_abort", 32'(bus.frame_abort), 32'd0);
      rst_n = 1'b1;
      rb = rxq_d.size();
      tb0 = tx_cnt;
      ab = abort_cnt;
      send_word(nom[1], 24);
      chk("mrst_quiet_rx", 32'(rxq_d.size() - rb), 32'd0);
      chk("mrst_quiet_tx", 32'(tx_cnt - tb0), 32'd0);
      chk("mrst_quiet_miso", 32'(bus.spi_miso), 32'd0);
      cs_rise();
      chk("mrst_no_abort", 32'(abort_cnt - ab), 32'd0);
      rb = rxq_d.size();
      cs_fall();
      for (int w = 0; w < 5; w++) send_word(nom[w], 24);
      cs_rise();
      frame_rx_check("mrst_frame", rb, nom);
   endtask

   task automatic test_latency();
      logic [7:0] d = 8'h5A;
      int lat = 0;
      logic [7:0] got_d = '0;
      logic got_done = 1'b0;
      sel = 1'b1;
      repeat (5) @(negedge clk);
      cs_fall();
      for (int i = 7; i > 0; i--) sclk_bit(d[i]);
      sclk = 1'b1;
      mosi = d[0];
      repeat (7) @(negedge clk);
      sclk = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (bus2.rx_valid) begin
            lat = c;
            got_d = bus2.rx_data;
            got_done = bus2.frame_done;
            break;
         end
      end
      check_cnt++;
      if (lat == 0) $display("FAIL lat_timeout: got no rx_valid in 20 cycles expected 4");
      else if (lat != 4) $display("FAIL lat_cycles: got %0d expected 4", lat);
      else pass_cnt++;
      chk("lat_rx_data", 32'(got_d), 32'h5A);
      chk("lat_done", 32'(got_done), 32'd1);
      chk("lat_idx", 32'(bus2.rx_word_idx), 32'd0);
      repeat (6) @(negedge clk);
      cs_rise();
      sel = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_nominal_frame();
      test_tx_path();
      test_abort();
      test_extra_clocks();
      test_reset_mid_frame();
      test_latency();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
